adc_drp_sched: RTL and testbench
================================

ADC_DRP_SCHED -- requirements
Module: adc_drp_sched

Interface
REQ-001 Parameter BITS, default 12, sample width kept from the upper bits of the 16-bit DRP word.
REQ-002 Parameter TIMEOUT, default 64, max cycles from drp_den to drp_drdy before abort.
REQ-003 clk  input  1  100 MHz clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 eoc  input  1  end-of-conversion pulse from the XADC wizard.
REQ-006 channel  input  5  channel of the conversion just ended.
REQ-007 drp_daddr  output  7  DRP address.
REQ-008 drp_den  output  1  DRP enable, one-cycle pulse.
REQ-009 drp_dwe  output  1  DRP write enable, valid with drp_den.
REQ-010 drp_di  output  16  DRP write data.
REQ-011 drp_do  input  16  DRP read data.
REQ-012 drp_drdy  input  1  DRP data-ready pulse.
REQ-013 host_req  input  1  host transfer request, held until host_ack.
REQ-014 host_we  input  1  host write (1) or read (0); stable while host_req is high.
REQ-015 host_addr  input  7  host DRP address; stable while host_req is high.
REQ-016 host_wdata  input  16  host write data; stable while host_req is high.
REQ-017 host_ack  output  1  one-cycle completion pulse.
REQ-018 host_rdata  output  16  read data; valid with host_ack.
REQ-019 sample0  output  BITS  latest channel 0x16 sample.
REQ-020 sample1  output  BITS  latest channel 0x1E sample.
REQ-021 done  output  1  one-cycle pulse when sample1 updates (end of sequence).
REQ-022 overrun  output  1  sticky flag: eoc arrived while a conversion read was still pending.
REQ-023 timeout_err  output  1  sticky flag: a DRP access timed out.

Function
REQ-024 FSM states: IDLE, CONV, HOST, WAIT; a single DRP access is outstanding at any time.
REQ-025 eoc with channel 0x16 or 0x1E sets the pending flag and latches the channel; eoc with any other channel is ignored.
REQ-026 In IDLE, the pending flag has priority over host_req; both present -> CONV first, then HOST.
REQ-027 CONV: drive drp_daddr = {2'b00, latched channel}, drp_dwe = 0, and pulse drp_den for 1 cycle, then enter WAIT; clear the pending flag on entry.
REQ-028 HOST: drive drp_daddr = host_addr, drp_dwe = host_we, drp_di = host_wdata, and pulse drp_den for 1 cycle, then enter WAIT.
REQ-029 Latency: eoc sampled at edge N -> drp_den high in cycle N+1 when IDLE with no access outstanding.
REQ-030 WAIT, CONV access, drp_drdy high -> register drp_do[15:16-BITS] into sample0 or sample1 on the next edge, then return to IDLE.
REQ-031 done pulses in the same cycle sample1 first shows the new value.
REQ-032 WAIT, HOST access, drp_drdy high -> host_ack for 1 cycle next cycle, host_rdata = drp_do (0x0000 for writes), then return to IDLE.
REQ-033 WAIT counter reaching TIMEOUT with no drp_drdy -> set timeout_err and return to IDLE; a host access also gets host_ack with host_rdata = 0xFFFF; a CONV access leaves its sample unchanged.
REQ-034 eoc for a valid channel while pending is already set -> set overrun and overwrite the latched channel; the newest conversion is read.
REQ-035 eoc in the same cycle that CONV clears pending -> pending stays set (the set wins).
REQ-036 drp_drdy outside WAIT is ignored.
REQ-037 drp_den never asserts while in WAIT.

Reset
REQ-038 rst forces IDLE immediately, including mid-access; pending, counter, overrun and timeout_err go to 0.
REQ-039 On rst: sample0 and sample1 are 0; drp_den, drp_dwe, host_ack and done are 0; drp_daddr, drp_di and host_rdata are 0.
REQ-040 overrun and timeout_err clear only on rst.

Configuration
REQ-041 Macro ADC_DRP_HOST_EN defined: the host port functions as specified.
REQ-042 Macro ADC_DRP_HOST_EN undefined: host_req is ignored, host_ack and host_rdata are tied 0, and the HOST state is not implemented.

Verification
REQ-043 Reset, then eoc with channel = 0x16 and drp_do = 0xABC0 with drdy 2 cycles after den -> drp_den in cycle N+1, daddr = 0x16, sample0 = 0xABC, done = 0.
REQ-044 eoc with channel = 0x1E and drp_do = 0x1230 -> sample1 = 0x123 and done pulses in that same cycle.
REQ-045 host_req (read, addr 0x00) in the same cycle as eoc with channel = 0x16 -> conversion read first, then host_ack with host_rdata = drp_do.
REQ-046 Second eoc with channel = 0x1E before the first read is issued -> overrun = 1 and daddr = 0x1E.
REQ-047 drdy withheld for 64 cycles on a host read -> timeout_err = 1, host_ack with 0xFFFF, FSM in IDLE.
REQ-048 rst asserted in WAIT, then drdy -> no sample update and no done; with the macro undefined, host_req -> no host_ack.

Source files
------------

// File: rtl/adc_drp_sched_if.sv
// rtl/adc_drp_sched_if.sv - DRP bus and host transfer port bundle for adc_drp_sched
interface adc_drp_sched_if;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        host_req;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;

  // scheduler side: drives the DRP access and answers the host
  modport master (
    output drp_daddr, drp_den, drp_dwe, drp_di, host_ack, host_rdata,
    input  drp_do, drp_drdy, host_req, host_we, host_addr, host_wdata
  );

  // XADC / host side
  modport slave (
    input  drp_daddr, drp_den, drp_dwe, drp_di, host_ack, host_rdata,
    output drp_do, drp_drdy, host_req, host_we, host_addr, host_wdata
  );
endinterface

// File: rtl/adc_drp_sched.sv
// rtl/adc_drp_sched.sv - XADC DRP scheduler: conversion reads plus optional host port (ADC_DRP_HOST_EN)
module adc_drp_sched #(
  parameter int BITS    = 12,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            eoc,
  input  logic [4:0]      channel,
  adc_drp_sched_if.master bus,
  output logic [BITS-1:0] sample0,
  output logic [BITS-1:0] sample1,
  output logic            done,
  output logic            overrun,
  output logic            timeout_err
);
  localparam logic [4:0]    CH0      = 5'h16;
  localparam logic [4:0]    CH1      = 5'h1E;
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CONV, HOST, WAIT} state_t;

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic [4:0]      chan_q, chan_d;
  logic            acc_host_q, acc_host_d;
  logic            acc_ch1_q, acc_ch1_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      daddr_q, daddr_d;
  logic            den_q, den_d;
  logic            dwe_q, dwe_d;
  logic [15:0]     di_q, di_d;
  logic            ack_q, ack_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [BITS-1:0] s0_q, s0_d;
  logic [BITS-1:0] s1_q, s1_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            to_q, to_d;
  logic            eoc_valid;
  logic            take_conv;
  logic            host_go;

  assign eoc_valid = eoc && (channel == CH0 || channel == CH1);

  // A host request arriving together with a valid eoc yields to the conversion,
  // which starts next cycle from the pending flag; the ack cycle is masked so a
  // requester still holding host_req does not launch a second transfer.
`ifdef ADC_DRP_HOST_EN
  assign host_go = bus.host_req && !ack_q && !eoc_valid;
`else
  assign host_go = 1'b0;
  logic unused_host;
  assign unused_host = ^{bus.host_req, bus.host_we, bus.host_addr, bus.host_wdata, ack_q, rdata_q};
`endif

  // next-state, access launch, completion capture and sticky flag logic
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    chan_d     = chan_q;
    acc_host_d = acc_host_q;
    acc_ch1_d  = acc_ch1_q;
    cnt_d      = cnt_q;
    daddr_d    = daddr_q;
    den_d      = 1'b0;
    dwe_d      = dwe_q;
    di_d       = di_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    to_d       = to_q;
    take_conv  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          take_conv  = 1'b1;
          state_d    = CONV;
          pending_d  = 1'b0;
          den_d      = 1'b1;
          dwe_d      = 1'b0;
          di_d       = 16'h0000;
          daddr_d    = {2'b00, chan_q};
          acc_host_d = 1'b0;
          acc_ch1_d  = (chan_q == CH1);
        end else if (host_go) begin
          state_d    = HOST;
          den_d      = 1'b1;
          dwe_d      = bus.host_we;
          di_d       = bus.host_wdata;
          daddr_d    = bus.host_addr;
          acc_host_d = 1'b1;
          acc_ch1_d  = 1'b0;
        end
      end
      CONV: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
`ifdef ADC_DRP_HOST_EN
      HOST: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
`endif
      WAIT: begin
        if (bus.drp_drdy) begin
          state_d = IDLE;
          if (acc_host_q) begin
            ack_d   = 1'b1;
            rdata_d = dwe_q ? 16'h0000 : bus.drp_do;
          end else if (acc_ch1_q) begin
            s1_d   = bus.drp_do[15:16-BITS];
            done_d = 1'b1;
          end else begin
            s0_d = bus.drp_do[15:16-BITS];
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          to_d    = 1'b1;
          if (acc_host_q) begin
            ack_d   = 1'b1;
            rdata_d = 16'hFFFF;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // a new valid eoc always re-arms pending, even on the edge that consumes it;
    // it is an overrun only if the previous channel was never read
    if (eoc_valid) begin
      pending_d = 1'b1;
      chan_d    = channel;
      if (pending_q && !take_conv) begin
        ovr_d = 1'b1;
      end
    end
  end

  // state and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      chan_q     <= 5'd0;
      acc_host_q <= 1'b0;
      acc_ch1_q  <= 1'b0;
      cnt_q      <= '0;
      daddr_q    <= 7'd0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      di_q       <= 16'h0000;
      ack_q      <= 1'b0;
      rdata_q    <= 16'h0000;
      s0_q       <= '0;
      s1_q       <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      chan_q     <= chan_d;
      acc_host_q <= acc_host_d;
      acc_ch1_q  <= acc_ch1_d;
      cnt_q      <= cnt_d;
      daddr_q    <= daddr_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      di_q       <= di_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
    end
  end

  assign bus.drp_daddr = daddr_q;
  assign bus.drp_den   = den_q;
  assign bus.drp_dwe   = dwe_q;
  assign bus.drp_di    = di_q;
`ifdef ADC_DRP_HOST_EN
  assign bus.host_ack   = ack_q;
  assign bus.host_rdata = rdata_q;
`else
  assign bus.host_ack   = 1'b0;
  assign bus.host_rdata = 16'h0000;
`endif
  assign sample0     = s0_q;
  assign sample1     = s1_q;
  assign done        = done_q;
  assign overrun     = ovr_q;
  assign timeout_err = to_q;
endmodule

// File: tb/tb_adc_drp_sched.sv
// tb/tb_adc_drp_sched.sv - scoreboard bench for adc_drp_sched with randomized conversion and host traffic
module tb_adc_drp_sched;
  localparam int BITS    = 12;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            eoc;
  logic [4:0]      channel;
  logic [BITS-1:0] sample0, sample1;
  logic            done, overrun, timeout_err;
  int              cyc = 0;
  int              tests = 0;
  int              fails = 0;

  adc_drp_sched_if bus();

  adc_drp_sched #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .eoc(eoc), .channel(channel), .bus(bus),
    .sample0(sample0), .sample1(sample1), .done(done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  addr;
    logic        we;
    logic [15:0] di;
    int          due;
  } den_t;

  den_t            den_q[$];
  logic [BITS-1:0] s0_q[$];
  logic [BITS-1:0] s1_q[$];
  logic [15:0]     ack_q[$];

  logic [BITS-1:0] m_s0, m_s1;
  logic            m_ovr, m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  // monitor: pops expectations whenever the DUT presents an access or a result
  initial begin
    logic [BITS-1:0] p0, p1;
    den_t e;
    p0 = '0;
    p1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        p0 = sample0;
        p1 = sample1;
      end else begin
        if (bus.drp_den) begin
          if (den_q.size() == 0) fail("den_unexpected", "drp_den with no access expected");
          else begin
            e = den_q.pop_front();
            chk("den_addr", 32'(bus.drp_daddr), 32'(e.addr));
            chk("den_we", 32'(bus.drp_dwe), 32'(e.we));
            if (e.we) chk("den_di", 32'(bus.drp_di), 32'(e.di));
            if (e.due >= 0) chk("den_latency", 32'(cyc), 32'(e.due));
          end
        end
        if (done) begin
          if (s1_q.size() == 0) fail("done_unexpected", "done with no sample1 update expected");
          else chk("sample1", 32'(sample1), 32'(s1_q.pop_front()));
        end else if (sample1 != p1) begin
          fail("sample1_no_done", "sample1 changed without done");
        end
        if (sample0 != p0) begin
          if (s0_q.size() == 0) fail("sample0_unexpected", "sample0 changed unexpectedly");
          else chk("sample0", 32'(sample0), 32'(s0_q.pop_front()));
        end
        if (bus.host_ack) begin
          if (ack_q.size() == 0) fail("ack_unexpected", "host_ack with no transfer expected");
          else chk("host_rdata", 32'(bus.host_rdata), 32'(ack_q.pop_front()));
        end
        p0 = sample0;
        p1 = sample1;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic pulse_eoc(input logic [4:0] ch);
    eoc = 1'b1;
    channel = ch;
    @(negedge clk);
    eoc = 1'b0;
  endtask

  task automatic wait_den(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.drp_den) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail("den_wait", "drp_den never asserted");
  endtask

  // drp_drdy arrives k cycles after the drp_den cycle
  task automatic respond(input int k, input logic [15:0] d);
    repeat (k) @(negedge clk);
    bus.drp_drdy = 1'b1;
    bus.drp_do = d;
    @(negedge clk);
    bus.drp_drdy = 1'b0;
  endtask

  // model rule: sample <= upper BITS of drp_do if drdy comes within TIMEOUT cycles
  task automatic expect_conv(input logic [4:0] ch, input logic [15:0] d, input int k);
    logic [BITS-1:0] v;
    v = d[15:16-BITS];
    if (k > TIMEOUT) m_to = 1'b1;
    else if (ch == 5'h16) begin s0_q.push_back(v); m_s0 = v; end
    else begin s1_q.push_back(v); m_s1 = v; end
  endtask

  function automatic logic [15:0] fresh_data(input logic [4:0] ch);
    logic [15:0] d;
    d = 16'($urandom);
    if (ch == 5'h16 && d[15:16-BITS] == m_s0) d[15] = ~d[15];
    if (ch == 5'h1E && d[15:16-BITS] == m_s1) d[15] = ~d[15];
    return d;
  endfunction

  task automatic conv(input logic [4:0] ch, input logic [15:0] d, input int k);
    bit ok;
    den_q.push_back('{{2'b00, ch}, 1'b0, 16'h0000, cyc + 2});
    pulse_eoc(ch);
    wait_den(ok);
    if (ok) begin
      expect_conv(ch, d, k);
      respond(k, d);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(m_to));
  endtask

  task automatic wait_ack();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 40; i++) begin
      if (bus.host_ack) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) fail("ack_wait", "host_ack never asserted");
    bus.host_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

`ifdef ADC_DRP_HOST_EN
  task automatic host_xfer(input logic we, input logic [6:0] a, input logic [15:0] wd,
                           input logic [15:0] rd, input int k);
    bit ok;
    den_q.push_back('{a, we, wd, -1});
    if (k > TIMEOUT) begin
      ack_q.push_back(16'hFFFF);
      m_to = 1'b1;
    end else begin
      ack_q.push_back(we ? 16'h0000 : rd);
    end
    bus.host_req = 1'b1;
    bus.host_we = we;
    bus.host_addr = a;
    bus.host_wdata = wd;
    @(negedge clk);
    wait_den(ok);
    if (ok && k <= TIMEOUT) respond(k, rd);
    wait_ack();
  endtask
`endif

  initial begin
    logic [4:0]  ch;
    logic [15:0] d, d2;
    int          k, r;
    bit          ok, seen;

    rst = 1'b1;
    eoc = 1'b0;
    channel = 5'd0;
    bus.drp_do = 16'h0000;
    bus.drp_drdy = 1'b0;
    bus.host_req = 1'b0;
    bus.host_we = 1'b0;
    bus.host_addr = 7'd0;
    bus.host_wdata = 16'h0000;
    m_s0 = '0; m_s1 = '0; m_ovr = 1'b0; m_to = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_daddr", 32'(bus.drp_daddr), 0);
    chk("rst_den", 32'(bus.drp_den), 0);
    chk("rst_dwe", 32'(bus.drp_dwe), 0);
    chk("rst_di", 32'(bus.drp_di), 0);
    chk("rst_ack", 32'(bus.host_ack), 0);
    chk("rst_rdata", 32'(bus.host_rdata), 0);
    chk("rst_sample0", 32'(sample0), 0);
    chk("rst_sample1", 32'(sample1), 0);
    chk("rst_done", 32'(done), 0);
    check_flags("rst");
    rst = 1'b0;
    @(negedge clk);

    // channel 0x16, drp_do 0xABC0, drdy two cycles after den
    conv(5'h16, 16'hABC0, 2);
    chk("first_sample0", 32'(sample0), 32'h0ABC);
    chk("first_done_low", 32'(done), 0);
    // channel 0x1E, drp_do 0x1230 -> done with sample1
    conv(5'h1E, 16'h1230, 2);
    chk("first_sample1", 32'(sample1), 32'h0123);
    check_flags("basic");

    // two eocs queued behind an outstanding read: newest channel wins, overrun set
    den_q.push_back('{7'h16, 1'b0, 16'h0000, cyc + 2});
    pulse_eoc(5'h16);
    wait_den(ok);
    den_q.push_back('{7'h1E, 1'b0, 16'h0000, -1});
    pulse_eoc(5'h16);
    pulse_eoc(5'h1E);
    m_ovr = 1'b1;
    d = fresh_data(5'h16);
    expect_conv(5'h16, d, 2);
    respond(2, d);
    wait_den(ok);
    d = fresh_data(5'h1E);
    expect_conv(5'h1E, d, 3);
    respond(3, d);
    repeat (2) @(negedge clk);
    check_flags("overrun");

    // eoc on the edge that consumes pending: it is still read afterwards
    den_q.push_back('{7'h16, 1'b0, 16'h0000, cyc + 2});
    den_q.push_back('{7'h1E, 1'b0, 16'h0000, -1});
    pulse_eoc(5'h16);
    pulse_eoc(5'h1E);
    wait_den(ok);
    d = fresh_data(5'h16);
    expect_conv(5'h16, d, 1);
    respond(1, d);
    wait_den(ok);
    d = fresh_data(5'h1E);
    expect_conv(5'h1E, d, 4);
    respond(4, d);
    repeat (2) @(negedge clk);

    // drdy exactly TIMEOUT cycles late is accepted, one later times out
    conv(5'h16, fresh_data(5'h16), TIMEOUT);
    check_flags("tmo_edge");
    conv(5'h1E, fresh_data(5'h1E), TIMEOUT + 1);
    check_flags("tmo_over");
    conv(5'h16, fresh_data(5'h16), 1);

`ifdef ADC_DRP_HOST_EN
    // host read arriving with an eoc: conversion first, then the host read
    den_q.push_back('{7'h16, 1'b0, 16'h0000, cyc + 2});
    den_q.push_back('{7'h00, 1'b0, 16'h0000, -1});
    d = fresh_data(5'h16);
    d2 = 16'($urandom);
    ack_q.push_back(d2);
    bus.host_req = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = 7'h00;
    pulse_eoc(5'h16);
    wait_den(ok);
    expect_conv(5'h16, d, 2);
    respond(2, d);
    wait_den(ok);
    respond(3, d2);
    wait_ack();
    host_xfer(1'b1, 7'h41, 16'h5A5A, 16'h1111, 2);
    host_xfer(1'b0, 7'h03, 16'h0000, 16'h0000, TIMEOUT + 1);
    check_flags("host");
`else
    // host port disabled: a held request is never acknowledged
    bus.host_req = 1'b1;
    bus.host_addr = 7'h00;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | bus.host_ack | bus.drp_den;
    end
    chk("host_disabled", 32'(seen), 0);
    chk("host_disabled_rdata", 32'(bus.host_rdata), 0);
    bus.host_req = 1'b0;
    @(negedge clk);
`endif

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        do ch = 5'($urandom); while (ch == 5'h16 || ch == 5'h1E);
        pulse_eoc(ch);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
          seen = seen | bus.drp_den;
          @(negedge clk);
        end
        chk("ignored_channel", 32'(seen), 0);
`ifdef ADC_DRP_HOST_EN
      end else if (r == 9) begin
        k = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : $urandom_range(1, 6);
        host_xfer(1'($urandom), 7'($urandom), 16'($urandom), 16'($urandom), k);
`endif
      end else begin
        ch = ($urandom_range(0, 1) == 0) ? 5'h16 : 5'h1E;
        k = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 1) : $urandom_range(1, 6);
        conv(ch, fresh_data(ch), k);
      end
      check_flags("rand");
    end

    // reset during an outstanding read: the late drdy must change nothing
    den_q.push_back('{7'h1E, 1'b0, 16'h0000, cyc + 2});
    pulse_eoc(5'h1E);
    wait_den(ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sample1", 32'(sample1), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    chk("midrst_timeout", 32'(timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    m_s0 = '0; m_s1 = '0; m_ovr = 1'b0; m_to = 1'b0;
    respond(0, 16'h5550);
    repeat (3) @(negedge clk);
    chk("post_rst_sample1", 32'(sample1), 0);
    chk("post_rst_sample0", 32'(sample0), 0);
    check_flags("post_rst");
    conv(5'h16, fresh_data(5'h16), 2);

    chk("den_q_drained", 32'(den_q.size()), 0);
    chk("s0_q_drained", 32'(s0_q.size()), 0);
    chk("s1_q_drained", 32'(s1_q.size()), 0);
    chk("ack_q_drained", 32'(ack_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
